// File: rtl/gpr_operand_fetch_if.sv
// Decode, register-file, writeback and execute signals of the operand fetch stage.
// The slave modport is the operand fetch stage; the master modport is its environment.
interface gpr_operand_fetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
);
    localparam int AW = $clog2(REG_COUNT);

    logic                  flush;

    logic                  inValid;
    logic                  inReady;
    logic [AW-1:0]         inRs;
    logic [AW-1:0]         inRt;
    logic [AW-1:0]         inRd;
    logic                  inWritesRd;

    logic [AW-1:0]         gprReadRegister1;
    logic [AW-1:0]         gprReadRegister2;
    logic [DATA_WIDTH-1:0] gprResult1;
    logic [DATA_WIDTH-1:0] gprResult2;

    logic                  wbValid;
    logic [AW-1:0]         wbRegister;
    logic [DATA_WIDTH-1:0] wbData;

    logic                  outValid;
    logic                  outReady;
    logic [DATA_WIDTH-1:0] outRsValue;
    logic [DATA_WIDTH-1:0] outRtValue;
    logic [AW-1:0]         outRd;
    logic                  outWritesRd;

    logic [REG_COUNT-1:0]  pendingMask;

    modport master (
        output flush,
        output inValid, inRs, inRt, inRd, inWritesRd,
        input  inReady,
        input  gprReadRegister1, gprReadRegister2,
        output gprResult1, gprResult2,
        output wbValid, wbRegister, wbData,
        input  outValid, outRsValue, outRtValue, outRd, outWritesRd,
        output outReady,
        input  pendingMask
    );

    modport slave (
        input  flush,
        input  inValid, inRs, inRt, inRd, inWritesRd,
        output inReady,
        output gprReadRegister1, gprReadRegister2,
        input  gprResult1, gprResult2,
        input  wbValid, wbRegister, wbData,
        output outValid, outRsValue, outRtValue, outRd, outWritesRd,
        input  outReady,
        output pendingMask
    );
endinterface

// File: rtl/gpr_operand_fetch.sv
// Register-read stage: holds one decoded instruction until its sources and destination
// are free of in-flight writes, captures operands with writeback bypass, tracks pending writes.
module gpr_operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input logic                 clock,
    input logic                 reset,
    gpr_operand_fetch_if.slave  bus
);
    localparam int AW = $clog2(REG_COUNT);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_WAIT,
        ST_FULL
    } state_t;

    state_t                r_state;
    state_t                w_nextState;

    logic [AW-1:0]         r_rs;
    logic [AW-1:0]         r_rt;
    logic [AW-1:0]         r_rd;
    logic                  r_writesRd;

    logic [DATA_WIDTH-1:0] r_outRsValue;
    logic [DATA_WIDTH-1:0] r_outRtValue;
    logic [AW-1:0]         r_outRd;
    logic                  r_outWritesRd;

    logic [REG_COUNT-1:0]  r_pending;
    logic [REG_COUNT-1:0]  w_pendingNext;

    logic                  w_clrRs;
    logic                  w_clrRt;
    logic                  w_clrRd;
    logic                  w_srcOkRs;
    logic                  w_srcOkRt;
    logic                  w_wawOk;
    logic                  w_inReady;
    logic                  w_inFire;
    logic                  w_outFire;
    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_rsValue;
    logic [DATA_WIDTH-1:0] w_rtValue;

    // A writeback to r this cycle releases any hazard on r and supplies its value.
    function automatic logic f_clr(input logic [AW-1:0] r, input logic wbValid,
                                   input logic [AW-1:0] wbRegister);
        return wbValid && (wbRegister == r) && (r != '0);
    endfunction

    always_comb begin
        w_clrRs   = f_clr(r_rs, bus.wbValid, bus.wbRegister);
        w_clrRt   = f_clr(r_rt, bus.wbValid, bus.wbRegister);
        w_clrRd   = f_clr(r_rd, bus.wbValid, bus.wbRegister);
        w_srcOkRs = (r_rs == '0) || !r_pending[r_rs] || w_clrRs;
        w_srcOkRt = (r_rt == '0) || !r_pending[r_rt] || w_clrRt;
        w_wawOk   = !r_writesRd || (r_rd == '0) || !r_pending[r_rd] || w_clrRd;
    end

    always_comb begin
        w_rsValue = bus.gprResult1;
        if (r_rs == '0) begin
            w_rsValue = '0;
        end else if (w_clrRs) begin
            w_rsValue = bus.wbData;
        end
        w_rtValue = bus.gprResult2;
        if (r_rt == '0) begin
            w_rtValue = '0;
        end else if (w_clrRt) begin
            w_rtValue = bus.wbData;
        end
    end

    // flush blocks both the issue handshake and any acceptance in the same cycle.
    always_comb begin
        w_outFire = (r_state == ST_FULL) && bus.outReady && !bus.flush;
        w_inReady = ((r_state == ST_EMPTY) || w_outFire) && !bus.flush;
        w_inFire  = bus.inValid && w_inReady;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_inFire) begin
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.flush) begin
                    w_nextState = ST_EMPTY;
                end else if (w_srcOkRs && w_srcOkRt && w_wawOk) begin
                    w_nextState = ST_FULL;
                    w_capture   = 1'b1;
                end
            end
            ST_FULL: begin
                if (bus.flush) begin
                    w_nextState = ST_EMPTY;
                end else if (bus.outReady) begin
                    w_nextState = w_inFire ? ST_WAIT : ST_EMPTY;
                end
            end
            default: begin
                w_nextState = ST_EMPTY;
            end
        endcase
    end

    // Set is applied after clear so an issue and a writeback to the same register leave it pending.
    always_comb begin
        w_pendingNext = r_pending;
        if (bus.wbValid && (bus.wbRegister != '0)) begin
            w_pendingNext[bus.wbRegister] = 1'b0;
        end
        if (w_outFire && r_outWritesRd && (r_outRd != '0)) begin
            w_pendingNext[r_outRd] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending     <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rd          <= '0;
            r_writesRd    <= 1'b0;
            r_outRsValue  <= '0;
            r_outRtValue  <= '0;
            r_outRd       <= '0;
            r_outWritesRd <= 1'b0;
        end else begin
            r_pending <= w_pendingNext;
            if (w_inFire) begin
                r_rs       <= bus.inRs;
                r_rt       <= bus.inRt;
                r_rd       <= bus.inRd;
                r_writesRd <= bus.inWritesRd;
            end
            if (w_capture) begin
                r_outRsValue  <= w_rsValue;
                r_outRtValue  <= w_rtValue;
                r_outRd       <= r_rd;
                r_outWritesRd <= r_writesRd;
            end
        end
    end

    assign bus.inReady          = w_inReady;
    assign bus.gprReadRegister1 = r_rs;
    assign bus.gprReadRegister2 = r_rt;
    assign bus.outValid         = (r_state == ST_FULL);
    assign bus.outRsValue       = r_outRsValue;
    assign bus.outRtValue       = r_outRtValue;
    assign bus.outRd            = r_outRd;
    assign bus.outWritesRd      = r_outWritesRd;
    assign bus.pendingMask      = r_pending;

endmodule

// File: tb/tb_gpr_operand_fetch.sv
// Bench for gpr_operand_fetch: directed hazard scenarios followed by random traffic,
// checked every cycle against a transaction-level model of the held instruction and scoreboard.
module tb_gpr_operand_fetch;
    localparam int DW = 32;
    localparam int RC = 32;
    localparam int AW = $clog2(RC);

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    gpr_operand_fetch_if #(.DATA_WIDTH(DW), .REG_COUNT(RC)) bus ();
    gpr_operand_fetch #(.DATA_WIDTH(DW), .REG_COUNT(RC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Register file; entry 0 deliberately holds garbage so the hard-wired zero is exercised.
    logic [DW-1:0] rf [RC];
    assign bus.gprResult1 = rf[bus.gprReadRegister1];
    assign bus.gprResult2 = rf[bus.gprReadRegister2];

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference model: at most one held instruction, captured or not, plus pending bits.
    bit            m_has, m_cap, m_w;
    logic [AW-1:0] m_rs, m_rt, m_rd;
    logic [DW-1:0] m_a, m_b;
    bit            m_pend [RC];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RC-1:0] pend_vec();
        logic [RC-1:0] v;
        for (int i = 0; i < RC; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic bit mclr(input logic [AW-1:0] r);
        return bus.wbValid && (bus.wbRegister == r) && (r != 0);
    endfunction

    function automatic bit avail(input logic [AW-1:0] r);
        return (r == 0) || !m_pend[r] || mclr(r);
    endfunction

    function automatic logic [DW-1:0] opval(input logic [AW-1:0] r);
        if (r == 0) return '0;
        if (mclr(r)) return bus.wbData;
        return rf[r];
    endfunction

    // Inputs are already driven (at the falling edge); check outputs, advance the model, clock once.
    task automatic step();
        bit exp_ready, fire_in, fire_out, out_w;
        logic [AW-1:0] out_rd;
        #1;
        if (reset) begin
            m_has = 0;
            m_cap = 0;
            for (int i = 0; i < RC; i++) m_pend[i] = 0;
        end else begin
            exp_ready = !bus.flush && (!m_has || (m_cap && bus.outReady));
            chk("inReady", bus.inReady, exp_ready);
            chk("outValid", bus.outValid, m_has && m_cap);
            chk("pendingMask", bus.pendingMask, pend_vec());
            if (m_has && m_cap) begin
                chk("outRsValue", bus.outRsValue, m_a);
                chk("outRtValue", bus.outRtValue, m_b);
                chk("outRd", bus.outRd, m_rd);
                chk("outWritesRd", bus.outWritesRd, m_w);
            end
            if (m_has && !m_cap) begin
                chk("readReg1", bus.gprReadRegister1, m_rs);
                chk("readReg2", bus.gprReadRegister2, m_rt);
            end
            fire_out = m_has && m_cap && bus.outReady && !bus.flush;
            fire_in  = bus.inValid && exp_ready;
            out_w    = m_w;
            out_rd   = m_rd;
            if (bus.flush) begin
                m_has = 0;
            end else if (m_has && !m_cap) begin
                if (avail(m_rs) && avail(m_rt) && (!m_w || avail(m_rd))) begin
                    m_a   = opval(m_rs);
                    m_b   = opval(m_rt);
                    m_cap = 1;
                end
            end else if (fire_out) begin
                m_has = 0;
            end
            if (bus.wbValid && bus.wbRegister != 0) m_pend[bus.wbRegister] = 0;
            if (fire_out && out_w && out_rd != 0) m_pend[out_rd] = 1;
            if (fire_in) begin
                m_has = 1;
                m_cap = 0;
                m_rs  = bus.inRs;
                m_rt  = bus.inRt;
                m_rd  = bus.inRd;
                m_w   = bus.inWritesRd;
            end
        end
        @(posedge clock);
        #1;
        if (bus.wbValid && bus.wbRegister != 0) rf[bus.wbRegister] = bus.wbData;
        @(negedge clock);
    endtask

    task automatic set_in(input bit v, input int rs, input int rt, input int rd, input bit w);
        bus.inValid    = v;
        bus.inRs       = AW'(rs);
        bus.inRt       = AW'(rt);
        bus.inRd       = AW'(rd);
        bus.inWritesRd = w;
    endtask

    task automatic set_wb(input bit v, input int r, input logic [DW-1:0] d);
        bus.wbValid    = v;
        bus.wbRegister = AW'(r);
        bus.wbData     = d;
    endtask

    logic [RC-1:0] saved;
    int            plist [$];

    initial begin
        for (int i = 0; i < RC; i++) rf[i] = $urandom;
        rf[0] = 32'hFFFF_FFFF;
        rf[5] = 32'h0000_1234;
        rf[6] = 32'h0000_ABCD;
        rf[7] = 32'h3333_0000;
        set_in(0, 0, 0, 0, 0);
        set_wb(0, 0, '0);
        bus.flush    = 0;
        bus.outReady = 0;
        reset        = 1;
        @(negedge clock);
        step();
        step();
        reset = 0;
        #1;
        chk("rst_outValid", bus.outValid, 0);
        chk("rst_inReady", bus.inReady, 1);
        chk("rst_pending", bus.pendingMask, 0);
        chk("rst_outRs", bus.outRsValue, 0);
        chk("rst_outRt", bus.outRtValue, 0);
        chk("rst_outRd", bus.outRd, 0);
        chk("rst_outWr", bus.outWritesRd, 0);

        // No hazard: two-cycle latency, then r7 becomes pending at issue.
        set_in(1, 5, 6, 7, 1);
        bus.outReady = 1;
        step();
        set_in(0, 0, 0, 0, 0);
        step();
        chk("nh_valid", bus.outValid, 1);
        chk("nh_rs", bus.outRsValue, 32'h1234);
        chk("nh_rt", bus.outRtValue, 32'hABCD);
        step();
        chk("nh_pend7", bus.pendingMask[7], 1);

        // RAW on r7 released by a same-cycle writeback while the file is stale.
        set_in(1, 7, 0, 1, 0);
        step();
        set_in(0, 0, 0, 0, 0);
        step();
        chk("raw_stall", bus.outValid, 0);
        set_wb(1, 7, 32'h55AA);
        step();
        set_wb(0, 0, '0);
        chk("raw_rs", bus.outRsValue, 32'h55AA);
        chk("raw_pend7", bus.pendingMask[7], 0);
        step();

        // WAW on r9, then set/clear collision on r3.
        set_in(1, 0, 0, 9, 1);
        step();
        set_in(0, 0, 0, 0, 0);
        step();
        step();
        chk("waw_pend9a", bus.pendingMask[9], 1);
        set_in(1, 0, 0, 9, 1);
        step();
        set_in(0, 0, 0, 0, 0);
        step();
        chk("waw_stall", bus.outValid, 0);
        set_wb(1, 9, 32'h0909_0909);
        step();
        set_wb(0, 0, '0);
        chk("waw_valid", bus.outValid, 1);
        step();
        chk("waw_pend9b", bus.pendingMask[9], 1);
        set_in(1, 0, 0, 3, 1);
        step();
        set_in(0, 0, 0, 0, 0);
        step();
        set_wb(1, 3, 32'h0303_0303);
        step();
        set_wb(0, 0, '0);
        chk("sc_pend3", bus.pendingMask[3], 1);

        // Register 0 operands and destination, plus an ignored writeback to r0.
        saved = pend_vec();
        set_in(1, 0, 0, 0, 1);
        step();
        set_in(0, 0, 0, 0, 0);
        set_wb(1, 0, 32'hDEAD_BEEF);
        step();
        set_wb(0, 0, '0);
        chk("z_rs", bus.outRsValue, 0);
        chk("z_rt", bus.outRtValue, 0);
        step();
        chk("z_pend", bus.pendingMask, saved);

        // Flush in FULL beats the handshake.
        set_in(1, 1, 2, 4, 1);
        step();
        set_in(0, 0, 0, 0, 0);
        bus.outReady = 0;
        step();
        chk("fl_full", bus.outValid, 1);
        saved = pend_vec();
        bus.flush    = 1;
        bus.outReady = 1;
        step();
        bus.flush = 0;
        chk("fl_valid", bus.outValid, 0);
        chk("fl_pend", bus.pendingMask, saved);

        // Reset while stalled on pending r9.
        set_in(1, 9, 0, 5, 0);
        step();
        set_in(0, 0, 0, 0, 0);
        step();
        reset = 1;
        step();
        reset = 0;
        chk("rw_pend", bus.pendingMask, 0);
        chk("rw_valid", bus.outValid, 0);

        for (int c = 0; c < 3000; c++) begin
            set_in($urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 9) < 7);
            bus.outReady = $urandom_range(0, 9) < 7;
            bus.flush    = m_has && ($urandom_range(0, 19) == 0);
            set_wb(0, 0, '0);
            if ($urandom_range(0, 9) < 3) begin
                plist.delete();
                for (int i = 1; i < RC; i++) if (m_pend[i]) plist.push_back(i);
                if (plist.size() > 0 && $urandom_range(0, 3) != 0)
                    set_wb(1, plist[$urandom_range(0, plist.size() - 1)], $urandom);
                else
                    set_wb(1, $urandom_range(0, 7), $urandom);
            end
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
